// File: rtl/msx_slot_ext.sv
// MSX cartridge slot to internal request bus bridge. Synchronises the slot
// strobes, decodes memory/I/O hits and runs one bus request per slot cycle.
module msx_slot_ext #(
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] IO_BASE     = 8'h98,
    parameter logic [7:0] IO_MASK     = 8'hFC,
    parameter bit         MEM_EN      = 1'b1,
    parameter bit         WAIT_EN     = 1'b1,
    parameter int         TIMEOUT     = 64
) (
    input  logic        clk42m,
    input  logic        reset,
    input  logic        p_slot_sltsl_n,
    input  logic        p_slot_mreq_n,
    input  logic        p_slot_ioreq_n,
    input  logic        p_slot_wr_n,
    input  logic        p_slot_rd_n,
    input  logic [15:0] p_slot_address,
    input  logic [7:0]  p_slot_data_in,
    output logic [7:0]  p_slot_data_out,
    output logic        p_slot_data_dir,
    output logic        p_slot_wait,
    output logic        p_slot_int,
    input  logic        int_n,
    output logic        bus_memreq,
    output logic        bus_ioreq,
    output logic [15:0] bus_address,
    output logic        bus_write,
    output logic        bus_valid,
    input  logic        bus_ready,
    output logic [7:0]  bus_wdata,
    input  logic [7:0]  bus_rdata,
    input  logic        bus_rdata_en,
    output logic        bus_timeout,
    output logic [2:0]  dbg_state
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_REQ     = 3'd1,
        ST_WAIT_RD = 3'd2,
        ST_HOLD    = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

    localparam int         SW       = 29;
    localparam logic [SW-1:0] SYNC_RST = {5'b11111, 24'h000000};
    localparam logic [7:0] TO_LAST  = 8'(TIMEOUT - 1);

    logic [SW-1:0]          sync_q [SYNC_STAGES];
    logic [SYNC_STAGES-1:0] fill_q;

    logic        sltsl_s, mreq_s, ioreq_s, wr_s, rd_s;
    logic [15:0] addr_s;
    logic [7:0]  din_s;

    always_ff @(posedge clk42m or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= SYNC_RST;
            fill_q <= '0;
        end else begin
            sync_q[0] <= {p_slot_sltsl_n, p_slot_mreq_n, p_slot_ioreq_n,
                          p_slot_wr_n, p_slot_rd_n, p_slot_address, p_slot_data_in};
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
            fill_q <= {fill_q[SYNC_STAGES-2:0], 1'b1};
        end
    end

    assign {sltsl_s, mreq_s, ioreq_s, wr_s, rd_s, addr_s, din_s} = sync_q[SYNC_STAGES-1];

    logic mem_hit, io_hit, hit, strobes_idle;

    always_comb begin
        strobes_idle = rd_s && wr_s;
        mem_hit      = MEM_EN && !sltsl_s && !mreq_s && !strobes_idle;
        io_hit       = !ioreq_s && !strobes_idle &&
                       ((addr_s[7:0] & IO_MASK) == (IO_BASE & IO_MASK));
        hit          = mem_hit || io_hit;
    end

    state_t      state_q;
    logic        armed_q, abort_q;
    logic [7:0]  cnt_q;
    logic        bus_valid_q, bus_memreq_q, bus_ioreq_q, bus_write_q, bus_timeout_q;
    logic [15:0] bus_address_q;
    logic [7:0]  bus_wdata_q, data_out_q;
    logic        data_dir_q, wait_q, int_q;

    // armed_q blocks a strobe that was already low at reset release (or is
    // still low from the previous request) from starting a new request.
    always_ff @(posedge clk42m or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            armed_q       <= 1'b0;
            abort_q       <= 1'b0;
            cnt_q         <= '0;
            bus_valid_q   <= 1'b0;
            bus_memreq_q  <= 1'b0;
            bus_ioreq_q   <= 1'b0;
            bus_write_q   <= 1'b0;
            bus_address_q <= '0;
            bus_wdata_q   <= '0;
            bus_timeout_q <= 1'b0;
            data_out_q    <= '0;
            data_dir_q    <= 1'b0;
            wait_q        <= 1'b0;
            int_q         <= 1'b0;
        end else begin
            int_q         <= !int_n;
            bus_timeout_q <= 1'b0;
            if (fill_q[SYNC_STAGES-1] && strobes_idle) armed_q <= 1'b1;

            case (state_q)
                ST_IDLE: begin
                    if (hit && armed_q) begin
                        state_q       <= ST_REQ;
                        armed_q       <= 1'b0;
                        abort_q       <= 1'b0;
                        bus_valid_q   <= 1'b1;
                        bus_address_q <= addr_s;
                        bus_write_q   <= !wr_s;
                        bus_wdata_q   <= din_s;
                        bus_memreq_q  <= mem_hit;
                        bus_ioreq_q   <= !mem_hit;
                        wait_q        <= WAIT_EN && wr_s;
                    end
                end
                ST_REQ: begin
                    if (strobes_idle) abort_q <= 1'b1;
                    if (bus_ready) begin
                        bus_valid_q <= 1'b0;
                        if (abort_q || strobes_idle) begin
                            state_q <= ST_IDLE;
                            wait_q  <= 1'b0;
                        end else if (bus_write_q) begin
                            state_q <= ST_DONE;
                        end else if (bus_rdata_en) begin
                            data_out_q <= bus_rdata;
                            data_dir_q <= 1'b1;
                            wait_q     <= 1'b0;
                            state_q    <= ST_HOLD;
                        end else begin
                            cnt_q   <= '0;
                            state_q <= ST_WAIT_RD;
                        end
                    end
                end
                ST_WAIT_RD: begin
                    if (bus_rdata_en) begin
                        data_out_q <= bus_rdata;
                        data_dir_q <= 1'b1;
                        wait_q     <= 1'b0;
                        state_q    <= ST_HOLD;
                    end else if (cnt_q == TO_LAST) begin
                        data_out_q    <= 8'hFF;
                        data_dir_q    <= 1'b1;
                        wait_q        <= 1'b0;
                        bus_timeout_q <= 1'b1;
                        state_q       <= ST_HOLD;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                ST_HOLD, ST_DONE: begin
                    if (strobes_idle) begin
                        state_q    <= ST_IDLE;
                        data_dir_q <= 1'b0;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign p_slot_data_out = data_out_q;
    assign p_slot_data_dir = data_dir_q;
    assign p_slot_wait     = wait_q;
    assign p_slot_int      = int_q;
    assign bus_memreq      = bus_memreq_q;
    assign bus_ioreq       = bus_ioreq_q;
    assign bus_address     = bus_address_q;
    assign bus_write       = bus_write_q;
    assign bus_valid       = bus_valid_q;
    assign bus_wdata       = bus_wdata_q;
    assign bus_timeout     = bus_timeout_q;
    assign dbg_state       = state_q;

endmodule

// File: tb/tb_msx_slot_ext.sv
// Directed bench for msx_slot_ext: hit decode latency, read/write flows,
// timeout substitution, abort, reset behaviour and interrupt pass-through.
module tb_msx_slot_ext;

    logic        clk42m = 1'b0;
    logic        reset;
    logic        p_slot_sltsl_n, p_slot_mreq_n, p_slot_ioreq_n, p_slot_wr_n, p_slot_rd_n;
    logic [15:0] p_slot_address;
    logic [7:0]  p_slot_data_in;
    logic [7:0]  p_slot_data_out;
    logic        p_slot_data_dir, p_slot_wait, p_slot_int;
    logic        int_n;
    logic        bus_memreq, bus_ioreq, bus_write, bus_valid, bus_ready;
    logic [15:0] bus_address;
    logic [7:0]  bus_wdata, bus_rdata;
    logic        bus_rdata_en, bus_timeout;
    logic [2:0]  dbg_state;

    int n_assert = 0;
    int n_fail   = 0;

    localparam logic [2:0] S_IDLE = 3'd0, S_REQ = 3'd1, S_WAIT_RD = 3'd2,
                           S_HOLD = 3'd3, S_DONE = 3'd4;

    msx_slot_ext dut (
        .clk42m(clk42m), .reset(reset),
        .p_slot_sltsl_n(p_slot_sltsl_n), .p_slot_mreq_n(p_slot_mreq_n),
        .p_slot_ioreq_n(p_slot_ioreq_n), .p_slot_wr_n(p_slot_wr_n),
        .p_slot_rd_n(p_slot_rd_n), .p_slot_address(p_slot_address),
        .p_slot_data_in(p_slot_data_in), .p_slot_data_out(p_slot_data_out),
        .p_slot_data_dir(p_slot_data_dir), .p_slot_wait(p_slot_wait),
        .p_slot_int(p_slot_int), .int_n(int_n),
        .bus_memreq(bus_memreq), .bus_ioreq(bus_ioreq), .bus_address(bus_address),
        .bus_write(bus_write), .bus_valid(bus_valid), .bus_ready(bus_ready),
        .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_rdata_en(bus_rdata_en),
        .bus_timeout(bus_timeout), .dbg_state(dbg_state)
    );

    // clock / reset
    always #5 clk42m = ~clk42m;

    task automatic tick(input int n);
        repeat (n) @(posedge clk42m);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // driver tasks
    task automatic release_strobes();
        p_slot_sltsl_n = 1'b1; p_slot_mreq_n = 1'b1; p_slot_ioreq_n = 1'b1;
        p_slot_wr_n = 1'b1; p_slot_rd_n = 1'b1;
    endtask

    task automatic mem_read(input logic [15:0] a);
        p_slot_address = a; p_slot_sltsl_n = 1'b0; p_slot_mreq_n = 1'b0; p_slot_rd_n = 1'b0;
    endtask

    int  n;
    logic seen_valid, seen_wait;

    initial begin
        reset = 1'b1;
        release_strobes();
        p_slot_address = '0; p_slot_data_in = '0; int_n = 1'b1;
        bus_ready = 1'b0; bus_rdata = '0; bus_rdata_en = 1'b0;
        tick(3);
        chk("rst_valid", bus_valid, 0);
        chk("rst_dir", p_slot_data_dir, 0);
        chk("rst_wait", p_slot_wait, 0);
        chk("rst_dout", p_slot_data_out, 0);
        chk("rst_state", dbg_state, S_IDLE);
        reset = 1'b0;
        tick(5);

        // I/O write 0x98 <- 0x12
        p_slot_address = 16'h0098; p_slot_data_in = 8'h12;
        p_slot_ioreq_n = 1'b0; p_slot_wr_n = 1'b0;
        tick(2);
        chk("iow_valid_e2", bus_valid, 0);
        tick(1);
        chk("iow_valid_e3", bus_valid, 1);
        chk("iow_ioreq", bus_ioreq, 1);
        chk("iow_memreq", bus_memreq, 0);
        chk("iow_addr", bus_address, 16'h0098);
        chk("iow_wdata", bus_wdata, 8'h12);
        chk("iow_write", bus_write, 1);
        chk("iow_wait", p_slot_wait, 0);
        tick(3);
        chk("iow_valid_held", bus_valid, 1);
        chk("iow_addr_held", bus_address, 16'h0098);
        bus_ready = 1'b1;
        tick(1);
        bus_ready = 1'b0;
        chk("iow_valid_drop", bus_valid, 0);
        chk("iow_state_done", dbg_state, S_DONE);
        chk("iow_wait_done", p_slot_wait, 0);
        release_strobes();
        tick(3);
        chk("iow_idle", dbg_state, S_IDLE);

        // memory read 0x89AB, data 0x56 ten cycles after bus_ready
        mem_read(16'h89AB);
        tick(3);
        chk("mr_valid", bus_valid, 1);
        chk("mr_memreq", bus_memreq, 1);
        chk("mr_write", bus_write, 0);
        chk("mr_addr", bus_address, 16'h89AB);
        chk("mr_wait", p_slot_wait, 1);
        bus_ready = 1'b1;
        tick(1);
        bus_ready = 1'b0;
        chk("mr_state_wait", dbg_state, S_WAIT_RD);
        chk("mr_valid_drop", bus_valid, 0);
        tick(9);
        chk("mr_wait_still", p_slot_wait, 1);
        bus_rdata = 8'h56; bus_rdata_en = 1'b1;
        tick(1);
        bus_rdata_en = 1'b0;
        chk("mr_dout", p_slot_data_out, 8'h56);
        chk("mr_dir", p_slot_data_dir, 1);
        chk("mr_wait_rel", p_slot_wait, 0);
        tick(3);
        chk("mr_dir_hold", p_slot_data_dir, 1);
        release_strobes();
        tick(2);
        chk("mr_dir_sync", p_slot_data_dir, 1);
        tick(1);
        chk("mr_dir_off", p_slot_data_dir, 0);
        chk("mr_idle", dbg_state, S_IDLE);
        tick(2);

        // memory read 0x1234, no data -> timeout after 64 cycles
        mem_read(16'h1234);
        tick(3);
        chk("to_valid", bus_valid, 1);
        bus_ready = 1'b1;
        tick(1);
        bus_ready = 1'b0;
        n = 0;
        while (n < 100) begin
            tick(1);
            n++;
            if (bus_timeout) break;
        end
        chk("to_cycles", 16'(n), 16'd64);
        chk("to_pulse", bus_timeout, 1);
        chk("to_dout", p_slot_data_out, 8'hFF);
        chk("to_dir", p_slot_data_dir, 1);
        chk("to_wait", p_slot_wait, 0);
        tick(1);
        chk("to_pulse_end", bus_timeout, 0);
        release_strobes();
        tick(3);
        chk("to_dir_off", p_slot_data_dir, 0);

        // misses: I/O 0x45 and memory with sltsl_n high
        p_slot_address = 16'h0045; p_slot_ioreq_n = 1'b0; p_slot_wr_n = 1'b0;
        seen_valid = 1'b0; seen_wait = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            seen_valid |= bus_valid;
            seen_wait  |= p_slot_wait;
        end
        chk("miss_io_valid", seen_valid, 0);
        chk("miss_io_wait", seen_wait, 0);
        release_strobes();
        tick(3);
        p_slot_address = 16'h4000; p_slot_mreq_n = 1'b0; p_slot_wr_n = 1'b0;
        seen_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            seen_valid |= bus_valid;
        end
        chk("miss_mem_valid", seen_valid, 0);
        chk("miss_mem_dir", p_slot_data_dir, 0);
        release_strobes();
        tick(3);

        // read 0x2345 with ready and data in the same cycle
        mem_read(16'h2345);
        tick(3);
        bus_ready = 1'b1; bus_rdata_en = 1'b1; bus_rdata = 8'h23;
        tick(1);
        bus_ready = 1'b0; bus_rdata_en = 1'b0;
        chk("direct_state", dbg_state, S_HOLD);
        chk("direct_dout", p_slot_data_out, 8'h23);
        chk("direct_dir", p_slot_data_dir, 1);
        chk("direct_wait", p_slot_wait, 0);
        release_strobes();
        tick(3);
        chk("direct_idle", dbg_state, S_IDLE);

        // strobe released while in REQ: request stays, data discarded
        mem_read(16'h0100);
        tick(3);
        chk("abort_valid", bus_valid, 1);
        release_strobes();
        tick(4);
        chk("abort_valid_held", bus_valid, 1);
        chk("abort_state_req", dbg_state, S_REQ);
        bus_ready = 1'b1; bus_rdata_en = 1'b1; bus_rdata = 8'h77;
        tick(1);
        bus_ready = 1'b0; bus_rdata_en = 1'b0;
        chk("abort_idle", dbg_state, S_IDLE);
        chk("abort_dir", p_slot_data_dir, 0);
        chk("abort_dout", p_slot_data_out, 8'h23);
        chk("abort_wait", p_slot_wait, 0);

        // stray rdata_en in IDLE
        bus_rdata_en = 1'b1; bus_rdata = 8'h99;
        tick(1);
        bus_rdata_en = 1'b0;
        chk("stray_state", dbg_state, S_IDLE);
        chk("stray_dout", p_slot_data_out, 8'h23);

        // interrupt pass-through
        int_n = 1'b0;
        tick(1);
        chk("int_on", p_slot_int, 1);
        int_n = 1'b1;
        tick(1);
        chk("int_off", p_slot_int, 0);

        // reset during WAIT_RD
        mem_read(16'h5555);
        tick(3);
        bus_ready = 1'b1;
        tick(1);
        bus_ready = 1'b0;
        chk("rr_state_wait", dbg_state, S_WAIT_RD);
        #2 reset = 1'b1;
        #1;
        chk("rr_state", dbg_state, S_IDLE);
        chk("rr_wait", p_slot_wait, 0);
        chk("rr_addr", bus_address, 0);
        chk("rr_memreq", bus_memreq, 0);
        chk("rr_dout", p_slot_data_out, 0);
        chk("rr_valid", bus_valid, 0);
        #3 reset = 1'b0;
        tick(8);
        chk("rr_no_rehit", bus_valid, 0);
        chk("rr_no_rehit_st", dbg_state, S_IDLE);
        release_strobes();
        tick(3);
        mem_read(16'hCDEF);
        tick(3);
        chk("rr_next_valid", bus_valid, 1);
        chk("rr_next_addr", bus_address, 16'hCDEF);
        bus_ready = 1'b1; bus_rdata_en = 1'b1; bus_rdata = 8'hA5;
        tick(1);
        bus_ready = 1'b0; bus_rdata_en = 1'b0;
        chk("rr_next_dout", p_slot_data_out, 8'hA5);
        chk("rr_next_dir", p_slot_data_dir, 1);
        release_strobes();
        tick(3);
        chk("rr_next_idle", dbg_state, S_IDLE);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/msx_slot_ext.md
MSX_SLOT_EXT -- requirements
Module: msx_slot_ext

Interface
REQ-001 Parameter SYNC_STAGES, default 2: synchroniser flops on every slot input (range 2..4).
REQ-002 Parameter IO_BASE, default 8'h98: I/O decode base compared on p_slot_address[7:0].
REQ-003 Parameter IO_MASK, default 8'hFC: I/O decode mask; hit when (addr[7:0] & IO_MASK) == (IO_BASE & IO_MASK).
REQ-004 Parameter MEM_EN, default 1: 0 disables memory-cycle decode.
REQ-005 Parameter WAIT_EN, default 1: 0 forces p_slot_wait low.
REQ-006 Parameter TIMEOUT, default 64: clk42m cycles allowed for read data before substitution (range 2..255).
REQ-007 Ports, clock and reset first:
clk42m  in  1  system clock, all logic rising-edge.
reset  in  1  asynchronous active-high reset.
p_slot_sltsl_n / p_slot_mreq_n / p_slot_ioreq_n / p_slot_wr_n / p_slot_rd_n  in  1 each  slot strobes, active-low, asynchronous.
p_slot_address  in  16  slot address.
p_slot_data_in  in  8  slot data bus, input side.
p_slot_data_out  out  8  slot data bus, output side.
p_slot_data_dir  out  1  1 = block drives slot data.
p_slot_wait  out  1  1 = hold Z80 in wait.
p_slot_int  out  1  1 = assert slot INT.
int_n  in  1  internal interrupt request, active-low.
bus_memreq / bus_ioreq  out  1 each  cycle type of current request.
bus_address  out  16  request address.
bus_write  out  1  1 = write, 0 = read.
bus_valid  out  1  request valid.
bus_ready  in  1  request accepted.
bus_wdata  out  8  write data.
bus_rdata  in  8  read data.
bus_rdata_en  in  1  bus_rdata valid, one-cycle pulse.
bus_timeout  out  1  one-cycle pulse when read timed out.

Function
REQ-008 All slot inputs pass SYNC_STAGES flops; decode uses synchronised values only.
REQ-009 Memory hit: MEM_EN & !sltsl_n & !mreq_n & (!rd_n | !wr_n); I/O hit: !ioreq_n & (!rd_n | !wr_n) & address match per REQ-003.
REQ-010 States: IDLE, REQ, WAIT_RD, HOLD, DONE.
REQ-011 IDLE: on hit, latch address, write (= !wr_n), wdata, type; go REQ; bus_valid high exactly SYNC_STAGES+1 rising edges after strobes are stable at first sampling flop.
REQ-012 REQ: bus_valid and latched fields held constant until bus_ready sampled high; then write -> DONE, read -> WAIT_RD.
REQ-013 bus_rdata_en in same cycle as bus_ready for a read: data captured, go HOLD directly.
REQ-014 WAIT_RD: capture bus_rdata on bus_rdata_en, go HOLD; counter reaching TIMEOUT cycles: data = 8'hFF, bus_timeout pulses one cycle, go HOLD.
REQ-015 HOLD/DONE of a read: p_slot_data_dir = 1, p_slot_data_out = captured byte, until synchronised rd_n high.
REQ-016 HOLD, DONE: return to IDLE when synchronised rd_n and wr_n both high; no new request before that (one request per slot cycle).
REQ-017 p_slot_wait = WAIT_EN & (state in REQ or WAIT_RD) & read request; low otherwise, never high on writes.
REQ-018 Strobe released while in REQ: bus_valid not retracted; after bus_ready, read data discarded, p_slot_data_dir stays 0, go IDLE.
REQ-019 bus_rdata_en outside WAIT_RD/REQ ignored.
REQ-020 p_slot_int = !int_n registered once (one-cycle latency).
REQ-021 Non-hit cycles (sltsl_n high, address miss): no bus_valid, p_slot_data_dir 0, p_slot_wait 0.

Reset
REQ-022 reset high asynchronously forces: state IDLE, synchronisers to inactive (strobes 1), bus_valid 0, bus_memreq 0, bus_ioreq 0, bus_write 0, bus_address 0, bus_wdata 0, p_slot_data_out 0, p_slot_data_dir 0, p_slot_wait 0, p_slot_int 0, bus_timeout 0, counter 0.
REQ-023 reset mid-cycle abandons request; after release, an already-active slot strobe is not treated as a new hit until it deasserts.

Verification
REQ-024 I/O write 0x98 data 0x12 -> bus_valid at edge 3, bus_ioreq 1, bus_address 0x0098, bus_wdata 0x12, bus_write 1; p_slot_wait stays 0.
REQ-025 Memory read 0x89AB, bus_ready at edge 4, bus_rdata_en with 0x56 ten cycles later -> p_slot_wait high until capture, p_slot_data_out 0x56 with dir 1 until rd_n high.
REQ-026 Memory read 0x1234 with no bus_rdata_en -> after 64 cycles bus_timeout one pulse, p_slot_data_out 0xFF, wait released.
REQ-027 I/O write to 0x45 (miss) and memory write with sltsl_n high -> bus_valid never asserted.
REQ-028 Read at 0x2345 with bus_ready and bus_rdata_en (0x23) in same cycle -> direct HOLD, output 0x23.
REQ-029 reset asserted during WAIT_RD -> all outputs at REQ-022 values immediately; next read 0xCDEF completes normally.
